mem_arbiter: RTL

Shares the single-ported, variable-latency unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 16-bit processor. It arbitrates with data-first priority plus a starvation guard for fetch. It sequences each access through an issue/wait/respond FSM and produces per-port done/stall signals for pipeline control. Timeout and unaligned-access errors are reported on `err`.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/arb_timeout_cnt.sv | 28 ++
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data unified-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DATA_W         = 16;
    localparam int unsigned ADDR_W         = 16;
    localparam int unsigned TO_CNT_W       = 5;
    localparam int unsigned STARVE_MAX_DEF = 2;
    localparam int unsigned TIMEOUT_DEF    = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

    // Latched access payload, held for the whole access.
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Cycle counter for the BUSY state; tc_c flags the last permitted cycle.
module arb_timeout_cnt
    import mem_arb_pkg::*;
#(
    parameter logic [TO_CNT_W-1:0] TERM = TO_CNT_W'(TIMEOUT_DEF - 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    logic [TO_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc_c = (count == TERM);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported memory between fetch and data with data-first
// priority, a fetch starvation guard, timeout and unaligned-access errors.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              busy,
    output logic              err
);

    localparam int unsigned SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

    arb_state_t        state, state_n;
    req_id_t           id, id_n;
    acc_t              acc, acc_n, sel;
    logic [SW-1:0]     starve, starve_n;
    logic              grant_dm;
    logic              to_clr, to_en, to_tc;
    logic              resp_fire;
    logic [DATA_W-1:0] resp_data;

    logic              mem_en_n, mem_wr_n, if_done_n, dm_done_n, err_n, busy_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n, if_rdata_n, dm_rdata_n;

    arb_timeout_cnt #(
        .TERM (TO_CNT_W'(TIMEOUT - 1))
    ) u_timeout (
        .clk  (clk),
        .rst  (rst),
        .clr  (to_clr),
        .en   (to_en),
        .tc_c (to_tc)
    );

    // Next state, latches and registered outputs for the following cycle.
    always_comb begin
        state_n     = state;
        id_n        = id;
        acc_n       = acc;
        starve_n    = starve;
        sel         = '0;
        grant_dm    = 1'b0;
        to_clr      = 1'b0;
        to_en       = 1'b0;
        resp_fire   = 1'b0;
        resp_data   = '0;
        mem_en_n    = 1'b0;
        mem_wr_n    = 1'b0;
        mem_addr_n  = '0;
        mem_wdata_n = '0;
        if_done_n   = 1'b0;
        dm_done_n   = 1'b0;
        if_rdata_n  = '0;
        dm_rdata_n  = '0;
        err_n       = 1'b0;
        busy_n      = 1'b0;

        unique case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    grant_dm = dm_req && (!if_req || (starve != SW'(STARVE_MAX)));
                    if (grant_dm) begin
                        id_n      = REQ_DM;
                        sel.wr    = dm_wr;
                        sel.addr  = dm_addr;
                        sel.wdata = dm_wdata;
                        if (!if_req) begin
                            starve_n = '0;
                        end else if (starve != SW'(STARVE_MAX)) begin
                            starve_n = starve + 1'b1;
                        end
                    end else begin
                        id_n      = REQ_IF;
                        sel.addr  = if_addr;
                        starve_n  = '0;
                    end
                    acc_n  = sel;
                    busy_n = 1'b1;
                    // An odd byte address never reaches memory.
                    if (sel.addr[0]) begin
                        state_n   = RESP;
                        resp_fire = 1'b1;
                        err_n     = 1'b1;
                    end else begin
                        state_n     = BUSY;
                        to_clr      = 1'b1;
                        mem_en_n    = 1'b1;
                        mem_wr_n    = sel.wr;
                        mem_addr_n  = sel.addr;
                        mem_wdata_n = sel.wdata;
                    end
                end
            end
            BUSY: begin
                to_en  = 1'b1;
                busy_n = 1'b1;
                if (mem_done) begin
                    state_n   = RESP;
                    resp_fire = 1'b1;
                    resp_data = acc.wr ? '0 : mem_rdata;
                end else if (to_tc) begin
                    state_n   = RESP;
                    resp_fire = 1'b1;
                    err_n     = 1'b1;
                end else begin
                    mem_wr_n    = acc.wr;
                    mem_addr_n  = acc.addr;
                    mem_wdata_n = acc.wdata;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (resp_fire) begin
            if (id_n == REQ_DM) begin
                dm_done_n  = 1'b1;
                dm_rdata_n = resp_data;
            end else begin
                if_done_n  = 1'b1;
                if_rdata_n = resp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            id        <= REQ_IF;
            acc       <= '0;
            starve    <= '0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            id        <= id_n;
            acc       <= acc_n;
            starve    <= starve_n;
            mem_en    <= mem_en_n;
            mem_wr    <= mem_wr_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            if_done   <= if_done_n;
            dm_done   <= dm_done_n;
            if_rdata  <= if_rdata_n;
            dm_rdata  <= dm_rdata_n;
            err       <= err_n;
            busy      <= busy_n;
        end
    end

    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

endmodule
